// File: rtl/decode_execute_register.sv
// Decode/execute pipeline register: captures the decode-stage control word and operands each cycle.
// Latency: 1 cycle from the _D inputs to the _E outputs.
// Stall and flush: flush inserts an all-zero bubble; stall holds the contents; flush wins over stall.
//
// Ports:
//   clk, rst               rising-edge clock; asynchronous active-high reset
//   stall_E, flush_E       hold / bubble-insert controls for the execute stage
//   valid_D, *_D           decode-stage slot: control word, operands, PC, register indices
//   valid_E, *_E           registered copies seen by the execute stage
//   bubble_count           saturating count of bubbles inserted (flushes plus invalid loads)
module decode_execute_register #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_E,
    input  logic             flush_E,
    input  logic             valid_D,
    input  logic             ctrl_register_file_WE_D,
    input  logic             ctrl_srcB_D,
    input  logic             ctrl_register_file_WA_D,
    input  logic             ctrl_data_memory_WE_D,
    input  logic             ctrl_result_D,
    input  logic [2:0]       ctrl_ALU_op_D,
    input  logic [XLEN-1:0]  rd1_D,
    input  logic [XLEN-1:0]  rd2_D,
    input  logic [XLEN-1:0]  sign_imm_D,
    input  logic [XLEN-1:0]  PC_D,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic [4:0]       rd_D,
    output logic             valid_E,
    output logic             ctrl_register_file_WE_E,
    output logic             ctrl_srcB_E,
    output logic             ctrl_register_file_WA_E,
    output logic             ctrl_data_memory_WE_E,
    output logic             ctrl_result_E,
    output logic [2:0]       ctrl_ALU_op_E,
    output logic [XLEN-1:0]  rd1_E,
    output logic [XLEN-1:0]  rd2_E,
    output logic [XLEN-1:0]  sign_imm_E,
    output logic [XLEN-1:0]  PC_E,
    output logic [4:0]       rs1_E,
    output logic [4:0]       rs2_E,
    output logic [4:0]       rd_E,
    output logic [CNT_W-1:0] bubble_count
);

    typedef struct packed {
        logic            valid;
        logic            rf_we;
        logic            srcb;
        logic            rf_wa;
        logic            dm_we;
        logic            result;
        logic [2:0]      alu_op;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } stage_t;

    stage_t           stage_d, stage_q;
    logic [CNT_W-1:0] bubble_d, bubble_q;
    logic             bubble_ins;

    always_comb begin
        stage_d    = stage_q;
        bubble_ins = 1'b0;
        if (flush_E) begin
            stage_d    = '0;
            bubble_ins = 1'b1;
        end else if (!stall_E) begin
            stage_d.valid  = valid_D;
            // Write enables are gated by valid so an empty slot can never
            // commit architectural state; the data fields still pass through.
            stage_d.rf_we  = ctrl_register_file_WE_D & valid_D;
            stage_d.dm_we  = ctrl_data_memory_WE_D & valid_D;
            stage_d.srcb   = ctrl_srcB_D;
            stage_d.rf_wa  = ctrl_register_file_WA_D;
            stage_d.result = ctrl_result_D;
            stage_d.alu_op = ctrl_ALU_op_D;
            stage_d.rd1    = rd1_D;
            stage_d.rd2    = rd2_D;
            stage_d.imm    = sign_imm_D;
            stage_d.pc     = PC_D;
            stage_d.rs1    = rs1_D;
            stage_d.rs2    = rs2_D;
            stage_d.rd     = rd_D;
            bubble_ins     = ~valid_D;
        end

        bubble_d = bubble_q;
        if (bubble_ins && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q  <= '0;
            bubble_q <= '0;
        end else begin
            stage_q  <= stage_d;
            bubble_q <= bubble_d;
        end
    end

    assign valid_E                 = stage_q.valid;
    assign ctrl_register_file_WE_E = stage_q.rf_we;
    assign ctrl_srcB_E             = stage_q.srcb;
    assign ctrl_register_file_WA_E = stage_q.rf_wa;
    assign ctrl_data_memory_WE_E   = stage_q.dm_we;
    assign ctrl_result_E           = stage_q.result;
    assign ctrl_ALU_op_E           = stage_q.alu_op;
    assign rd1_E                   = stage_q.rd1;
    assign rd2_E                   = stage_q.rd2;
    assign sign_imm_E              = stage_q.imm;
    assign PC_E                    = stage_q.pc;
    assign rs1_E                   = stage_q.rs1;
    assign rs2_E                   = stage_q.rs2;
    assign rd_E                    = stage_q.rd;
    assign bubble_count            = bubble_q;

endmodule

// File: tb/tb_decode_execute_register.sv
module tb_decode_execute_register;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic        srcb;
        logic        wa;
        logic        dmwe;
        logic        res;
        logic [2:0]  op;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } f_t;

    typedef struct {
        logic stall;
        logic flush;
        f_t   d;
        f_t   exp;
        int   cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, flush = 1'b0;
    logic        s_stall = 1'b1, s_flush = 1'b0;
    f_t          din;
    f_t          dout, sout;
    logic [15:0] cnt;
    logic [3:0]  s_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    decode_execute_register #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall_E(stall), .flush_E(flush),
        .valid_D(din.valid), .ctrl_register_file_WE_D(din.we), .ctrl_srcB_D(din.srcb),
        .ctrl_register_file_WA_D(din.wa), .ctrl_data_memory_WE_D(din.dmwe),
        .ctrl_result_D(din.res), .ctrl_ALU_op_D(din.op),
        .rd1_D(din.rd1), .rd2_D(din.rd2), .sign_imm_D(din.imm), .PC_D(din.pc),
        .rs1_D(din.rs1), .rs2_D(din.rs2), .rd_D(din.rd),
        .valid_E(dout.valid), .ctrl_register_file_WE_E(dout.we), .ctrl_srcB_E(dout.srcb),
        .ctrl_register_file_WA_E(dout.wa), .ctrl_data_memory_WE_E(dout.dmwe),
        .ctrl_result_E(dout.res), .ctrl_ALU_op_E(dout.op),
        .rd1_E(dout.rd1), .rd2_E(dout.rd2), .sign_imm_E(dout.imm), .PC_E(dout.pc),
        .rs1_E(dout.rs1), .rs2_E(dout.rs2), .rd_E(dout.rd),
        .bubble_count(cnt)
    );

    decode_execute_register #(.XLEN(32), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .stall_E(s_stall), .flush_E(s_flush),
        .valid_D(din.valid), .ctrl_register_file_WE_D(din.we), .ctrl_srcB_D(din.srcb),
        .ctrl_register_file_WA_D(din.wa), .ctrl_data_memory_WE_D(din.dmwe),
        .ctrl_result_D(din.res), .ctrl_ALU_op_D(din.op),
        .rd1_D(din.rd1), .rd2_D(din.rd2), .sign_imm_D(din.imm), .PC_D(din.pc),
        .rs1_D(din.rs1), .rs2_D(din.rs2), .rd_D(din.rd),
        .valid_E(sout.valid), .ctrl_register_file_WE_E(sout.we), .ctrl_srcB_E(sout.srcb),
        .ctrl_register_file_WA_E(sout.wa), .ctrl_data_memory_WE_E(sout.dmwe),
        .ctrl_result_E(sout.res), .ctrl_ALU_op_E(sout.op),
        .rd1_E(sout.rd1), .rd2_E(sout.rd2), .sign_imm_E(sout.imm), .PC_E(sout.pc),
        .rs1_E(sout.rs1), .rs2_E(sout.rs2), .rd_E(sout.rd),
        .bubble_count(s_cnt)
    );

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] req);
        total_cnt++;
        if (act !== req) $display("FAIL %s actual=%h required=%h", nm, act, req);
        else pass_cnt++;
    endtask

    function automatic vec_t mk(input logic st, input logic fl, input f_t d, input f_t e, input int c);
        vec_t v;
        v.stall = st; v.flush = fl; v.d = d; v.exp = e; v.cnt = c;
        return v;
    endfunction

    // valid, we, srcb, wa, dmwe, res, op, rd1, rd2, imm, pc, rs1, rs2, rd
    localparam f_t LW    = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'h0,
                            32'h8, 32'h40, 5'd1, 5'd0, 5'd5};
    localparam f_t ADD   = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h3, 32'h4,
                            32'h0, 32'h44, 5'd1, 5'd2, 5'd6};
    localparam f_t ODD   = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b101, 32'h7, 32'h9,
                            32'h0, 32'h4c, 5'd3, 5'd4, 5'd10};
    localparam f_t INV   = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b111, 32'hDEADBEEF, 32'h1234,
                            32'hFFFFFFF0, 32'h48, 5'd7, 5'd8, 5'd9};
    localparam f_t INV_E = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 32'hDEADBEEF, 32'h1234,
                            32'hFFFFFFF0, 32'h48, 5'd7, 5'd8, 5'd9};
    localparam f_t ZERO  = '0;

    initial begin
        vec_t vt[16];
        vt[0]  = mk(1'b0, 1'b0, LW,  LW,    0);  // first load after reset
        vt[1]  = mk(1'b0, 1'b0, ADD, ADD,   0);
        vt[2]  = mk(1'b1, 1'b0, LW,  ADD,   0);  // stall x3 holds add
        vt[3]  = mk(1'b1, 1'b0, LW,  ADD,   0);
        vt[4]  = mk(1'b1, 1'b0, LW,  ADD,   0);
        vt[5]  = mk(1'b0, 1'b0, LW,  LW,    0);  // stall released
        vt[6]  = mk(1'b1, 1'b1, ADD, ZERO,  1);  // flush beats stall
        vt[7]  = mk(1'b0, 1'b0, INV, INV_E, 2);  // invalid slot
        vt[8]  = mk(1'b0, 1'b0, ODD, ODD,   2);  // unusual ALU op passes through
        vt[9]  = mk(1'b0, 1'b1, LW,  ZERO,  3);
        vt[10] = mk(1'b1, 1'b0, LW,  ZERO,  3);  // holding a bubble does not count
        vt[11] = mk(1'b0, 1'b1, LW,  ZERO,  4);
        vt[12] = mk(1'b0, 1'b1, LW,  ZERO,  5);
        vt[13] = mk(1'b0, 1'b1, LW,  ZERO,  6);
        vt[14] = mk(1'b0, 1'b1, LW,  ZERO,  7);
        vt[15] = mk(1'b0, 1'b0, LW,  LW,    7);

        // Reset with all inputs at all-ones.
        din = '1;
        #1;
        check("reset_out", dout, ZERO);
        check("reset_cnt", cnt, 16'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("reset_hold_out%0d", i), dout, ZERO);
            check($sformatf("reset_hold_cnt%0d", i), cnt, 16'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            stall = vt[i].stall;
            flush = vt[i].flush;
            din   = vt[i].d;
            @(posedge clk); #1;
            check($sformatf("vec%0d_out", i), dout, vt[i].exp);
            check($sformatf("vec%0d_cnt", i), cnt, 16'(vt[i].cnt));
            if (!dout.valid)
                check($sformatf("vec%0d_inv", i), {dout.we, dout.dmwe}, 2'b00);
        end

        // Async reset between edges while valid_E=1 and bubble_count=7.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out", dout, ZERO);
        check("async_rst_cnt", cnt, 16'd0);
        @(posedge clk); #1;
        check("rst_held_load", dout, ZERO);
        stall = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        check("rst_vs_flush_cnt", cnt, 16'd0);
        stall = 1'b0; flush = 1'b0;
        din   = ADD;
        rst   = 1'b0;
        @(posedge clk); #1;
        check("post_rst_load", dout, ADD);
        check("post_rst_cnt", cnt, 16'd0);

        // Saturation with a 4-bit counter.
        s_stall = 1'b0;
        s_flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check($sformatf("sat%0d", i), s_cnt, (i + 1 > 15) ? 4'd15 : 4'(i + 1));
        end
        check("sat_out_zero", sout, ZERO);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
